// File: rtl/prga_arb_wrr.sv
// -----------------------------------------------------------------------------
// prga_arb_wrr
//   Weighted round-robin arbiter with grant locking. One of NUM_CANDIDATES
//   requesters holds the grant for up to WEIGHT[i] acknowledged beats. A
//   per-candidate lock input keeps the grant past its quota. The grant then
//   rotates fairly to the next requester after the previous grantee. Every
//   state update is qualified by ce.
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   ce            clock enable; no state changes while low (ack ignored)
//   req           level request per candidate
//   lock          lock[grant_idx]=1 holds the grant once its credit is spent
//   weights       per-candidate quota, field i = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//                 (a zero weight behaves as a weight of one)
//   ack           the grantee consumed one beat this cycle
//   grant_valid   grant_idx / grant_onehot are valid (registered)
//   grant_idx     current grantee (registered)
//   grant_onehot  one-hot of grant_idx, all zero while !grant_valid (registered)
//   next_idx      combinational: the candidate an arbitration from ptr picks now
// -----------------------------------------------------------------------------
module prga_arb_wrr #(
  parameter int INDEX_WIDTH    = 3,
  parameter int NUM_CANDIDATES = 5,
  parameter int WEIGHT_WIDTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     ce,
  input  logic [NUM_CANDIDATES-1:0]                req,
  input  logic [NUM_CANDIDATES-1:0]                lock,
  input  logic [NUM_CANDIDATES*WEIGHT_WIDTH-1:0]   weights,
  input  logic                                     ack,
  output logic                                     grant_valid,
  output logic [INDEX_WIDTH-1:0]                   grant_idx,
  output logic [NUM_CANDIDATES-1:0]                grant_onehot,
  output logic [INDEX_WIDTH-1:0]                   next_idx
);

  localparam int N  = NUM_CANDIDATES;
  localparam int IW = INDEX_WIDTH;
  localparam int WW = WEIGHT_WIDTH;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [WW-1:0]   credit_reg;
  logic            grant_valid_reg;
  logic [IW-1:0]   grant_idx_reg;
  logic [N-1:0]    grant_onehot_reg;

  // ---------------------------------------------------------------------------
  // Round-robin search: first requester at or above start, wrapping to 0.
  // Returns {found, index}; index falls back to start when nothing requests.
  // Two passes over constant indices: the "upper" pass only accepts
  // candidates >= start, the "lower" pass accepts anything. Iterating from
  // the top down leaves the lowest matching index in each result.
  // ---------------------------------------------------------------------------
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r,
                                          input logic [IW-1:0] start);
    logic          found_hi;
    logic          found_lo;
    logic [IW-1:0] pick_hi;
    logic [IW-1:0] pick_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = start;
    pick_lo  = start;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) begin
        if (IW'(i) >= start) begin
          found_hi = 1'b1;
          pick_hi  = IW'(i);
        end
        found_lo = 1'b1;
        pick_lo  = IW'(i);
      end
    end
    return {found_lo, (found_hi ? pick_hi : pick_lo)};
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == idx) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Effective weights: zero is promoted to one so every grant lasts at least
  // one acknowledged beat.
  // ---------------------------------------------------------------------------
  logic [WW-1:0] eff_weight [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_weight
    logic [WW-1:0] raw_weight;
    assign raw_weight     = weights[gi*WW +: WW];
    assign eff_weight[gi] = (raw_weight == '0) ? WW'(1) : raw_weight;
  end

  // ---------------------------------------------------------------------------
  // Candidate selection from the current pointer (IDLE grants and next_idx)
  // ---------------------------------------------------------------------------
  logic [IW:0]   idle_pick;
  logic [IW-1:0] idle_idx;
  logic [WW-1:0] idle_weight;

  assign idle_pick = rr_pick(req, ptr_reg);
  assign idle_idx  = idle_pick[IW-1:0];
  assign next_idx  = idle_idx;

  // ---------------------------------------------------------------------------
  // Candidate selection for a re-arbitration out of GRANT. The pointer moves
  // to the slot after the current grantee, so the grantee itself is searched
  // last. On a withdraw req[g] is already low, so the same search excludes it
  // without an explicit mask.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] rearb_ptr;
  logic [IW:0]   rearb_pick;
  logic          rearb_found;
  logic [IW-1:0] rearb_idx;
  logic [WW-1:0] rearb_weight;

  assign rearb_ptr   = (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;
  assign rearb_pick  = rr_pick(req, rearb_ptr);
  assign rearb_found = rearb_pick[IW];
  assign rearb_idx   = rearb_pick[IW-1:0];

  // Weight lookup by mux rather than array index keeps the select width
  // independent of INDEX_WIDTH vs. NUM_CANDIDATES.
  always_comb begin
    idle_weight  = WW'(1);
    rearb_weight = WW'(1);
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == idle_idx) begin
        idle_weight = eff_weight[i];
      end
      if (IW'(i) == rearb_idx) begin
        rearb_weight = eff_weight[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grantee-qualified request / lock, taken through the registered one-hot
  // so non-grantee lock bits are ignored by construction.
  // ---------------------------------------------------------------------------
  logic req_g;
  logic lock_g;
  logic credit_last;
  logic burst_end;

  assign req_g       = |(req & grant_onehot_reg);
  assign lock_g      = |(lock & grant_onehot_reg);
  assign credit_last = (credit_reg <= WW'(1));
  // Withdraw has priority over everything; otherwise only an ack on the last
  // credit without lock ends the burst.
  assign burst_end   = !req_g || (ack && credit_last && !lock_g);

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      credit_reg       <= '0;
      grant_valid_reg  <= 1'b0;
      grant_idx_reg    <= '0;
      grant_onehot_reg <= '0;
    end else if (ce) begin
      if (state_reg == IDLE) begin
        if (|req) begin
          state_reg        <= GRANT;
          grant_valid_reg  <= 1'b1;
          grant_idx_reg    <= idle_idx;
          grant_onehot_reg <= to_onehot(idle_idx);
          credit_reg       <= idle_weight;
        end
      end else begin
        if (burst_end) begin
          ptr_reg <= rearb_ptr;
          if (rearb_found) begin
            // Back-to-back handover: grant_valid stays high.
            grant_idx_reg    <= rearb_idx;
            grant_onehot_reg <= to_onehot(rearb_idx);
            credit_reg       <= rearb_weight;
          end else begin
            state_reg        <= IDLE;
            grant_valid_reg  <= 1'b0;
            grant_onehot_reg <= '0;
          end
        end else if (ack && !credit_last) begin
          credit_reg <= credit_reg - 1'b1;
        end
        // ack with lock on the last credit, or no ack: hold everything.
      end
    end
  end

  assign grant_valid  = grant_valid_reg;
  assign grant_idx    = grant_idx_reg;
  assign grant_onehot = grant_onehot_reg;

endmodule
